// File: rtl/reg_bank.sv
// reg_bank: DEPTH x WIDTH register file with one write port, two registered read ports and sticky per-entry written flags.
// Define REG_BANK_BYPASS_EN to forward same-cycle write data to a read of the same address.
module reg_bank #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int AW       = 3,
  parameter int ZERO_REG = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re_a,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic             re_b,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  output logic [DEPTH-1:0] written
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             write_ok;

  // An address is usable when it maps to a real entry and is not the hard-wired zero register.
  function automatic logic legal(input logic [AW-1:0] addr);
    legal = (32'(addr) < 32'(DEPTH)) && !((ZERO_REG != 0) && (addr == '0));
  endfunction

  function automatic logic [WIDTH-1:0] stored(input logic [AW-1:0] addr);
    stored = legal(addr) ? mem[addr] : '0;
  endfunction

  assign write_ok = we && legal(waddr);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      written <= '0;
    end else if (write_ok) begin
      mem[waddr]     <= wdata;
      written[waddr] <= 1'b1;
    end
  end

  // Reads sample the array before this edge's write lands unless forwarding is enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
`ifdef REG_BANK_BYPASS_EN
      if (re_a) rdata_a <= (write_ok && (waddr == raddr_a)) ? wdata : stored(raddr_a);
      if (re_b) rdata_b <= (write_ok && (waddr == raddr_b)) ? wdata : stored(raddr_b);
`else
      if (re_a) rdata_a <= stored(raddr_a);
      if (re_b) rdata_b <= stored(raddr_b);
`endif
    end
  end

endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: scoreboard bench for reg_bank; a default instance and a DEPTH=6/ZERO_REG=1 instance share clock and reset.
// Read expectations are queued at issue time and popped by a monitor one cycle later.
module tb_reg_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic we1, re_a1, re_b1, we2, re_a2, re_b2;
  logic [2:0] waddr1, raddr_a1, raddr_b1, waddr2, raddr_a2, raddr_b2;
  logic [15:0] wdata1, wdata2;
  logic [15:0] rdata_a1, rdata_b1, rdata_a2, rdata_b2;
  logic [7:0] written1;
  logic [5:0] written2;

  int tests_run = 0;
  int tests_failed = 0;

  logic [15:0] qa1[$], qb1[$], qa2[$], qb2[$];
  logic pend_a1 = 1'b0, pend_b1 = 1'b0, pend_a2 = 1'b0, pend_b2 = 1'b0;

  reg_bank #(.WIDTH(16), .DEPTH(8), .AW(3), .ZERO_REG(0)) u_dut1 (
    .clk(clk), .reset(rst), .we(we1), .waddr(waddr1), .wdata(wdata1),
    .re_a(re_a1), .raddr_a(raddr_a1), .rdata_a(rdata_a1),
    .re_b(re_b1), .raddr_b(raddr_b1), .rdata_b(rdata_b1),
    .written(written1)
  );

  reg_bank #(.WIDTH(16), .DEPTH(6), .AW(3), .ZERO_REG(1)) u_dut2 (
    .clk(clk), .reset(rst), .we(we2), .waddr(waddr2), .wdata(wdata2),
    .re_a(re_a2), .raddr_a(raddr_a2), .rdata_a(rdata_a2),
    .re_b(re_b2), .raddr_b(raddr_b2), .rdata_b(rdata_b2),
    .written(written2)
  );

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
    end
  endtask

  task automatic noteOrphan(input string name, input logic [15:0] actual);
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL %s: read data 0x%04h with no expectation queued", name, actual);
  endtask

  // A read issued (and not overridden by reset) at an edge presents its data for the following half cycle.
  always @(posedge clk) begin
    pend_a1 <= re_a1 && !rst;
    pend_b1 <= re_b1 && !rst;
    pend_a2 <= re_a2 && !rst;
    pend_b2 <= re_b2 && !rst;
  end

  always @(negedge clk) begin
    if (pend_a1) begin
      if (qa1.size() == 0) noteOrphan("dut1_port_a", rdata_a1);
      else checkOutput("dut1_port_a", rdata_a1, qa1.pop_front());
    end
    if (pend_b1) begin
      if (qb1.size() == 0) noteOrphan("dut1_port_b", rdata_b1);
      else checkOutput("dut1_port_b", rdata_b1, qb1.pop_front());
    end
    if (pend_a2) begin
      if (qa2.size() == 0) noteOrphan("dut2_port_a", rdata_a2);
      else checkOutput("dut2_port_a", rdata_a2, qa2.pop_front());
    end
    if (pend_b2) begin
      if (qb2.size() == 0) noteOrphan("dut2_port_b", rdata_b2);
      else checkOutput("dut2_port_b", rdata_b2, qb2.pop_front());
    end
  end

  // Drives one cycle of stimulus onto instance d (1 or 2); the other instance idles.
  task automatic applyStimulus(input int d, input logic w, input logic [2:0] wa, input logic [15:0] wd,
                               input logic ra, input logic [2:0] aa, input logic rb, input logic [2:0] ab);
    @(negedge clk);
    we1 = 1'b0; waddr1 = '0; wdata1 = '0; re_a1 = 1'b0; raddr_a1 = '0; re_b1 = 1'b0; raddr_b1 = '0;
    we2 = 1'b0; waddr2 = '0; wdata2 = '0; re_a2 = 1'b0; raddr_a2 = '0; re_b2 = 1'b0; raddr_b2 = '0;
    if (d == 1) begin
      we1 = w; waddr1 = wa; wdata1 = wd; re_a1 = ra; raddr_a1 = aa; re_b1 = rb; raddr_b1 = ab;
    end else begin
      we2 = w; waddr2 = wa; wdata2 = wd; re_a2 = ra; raddr_a2 = aa; re_b2 = rb; raddr_b2 = ab;
    end
  endtask

  task automatic idle();
    applyStimulus(1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 3'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    we1 = 1'b0; waddr1 = '0; wdata1 = '0; re_a1 = 1'b0; raddr_a1 = '0; re_b1 = 1'b0; raddr_b1 = '0;
    we2 = 1'b0; waddr2 = '0; wdata2 = '0; re_a2 = 1'b0; raddr_a2 = '0; re_b2 = 1'b0; raddr_b2 = '0;
    idle();
    idle();
    checkOutput("reset_rdata_a1", rdata_a1, 16'h0000);
    checkOutput("reset_rdata_b1", rdata_b1, 16'h0000);
    checkOutput("reset_written1", {8'h00, written1}, 16'h0000);
    checkOutput("reset_written2", {10'h000, written2}, 16'h0000);
    rst = 1'b0;

    // Every entry reads zero after reset on both ports.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 1'b0, 3'd0, 16'h0, 1'b1, 3'(i), 1'b1, 3'(7 - i));
      qa1.push_back(16'h0000);
      qb1.push_back(16'h0000);
    end
    idle();
    checkOutput("empty_written1", {8'h00, written1}, 16'h0000);

    // Basic write then read, followed by hold with re low.
    applyStimulus(1, 1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 1'b0, 3'd0);
    applyStimulus(1, 1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 1'b0, 3'd0);
    qa1.push_back(16'hBEEF);
    idle();
    checkOutput("written_after_addr3", {8'h00, written1}, 16'h0008);
    for (int i = 0; i < 5; i++) begin
      idle();
      checkOutput("hold_rdata_a1", rdata_a1, 16'hBEEF);
    end

    // Same-cycle write and read of entry 5.
    applyStimulus(1, 1'b1, 3'd5, 16'h1111, 1'b0, 3'd0, 1'b0, 3'd0);
    applyStimulus(1, 1'b1, 3'd5, 16'h2222, 1'b1, 3'd5, 1'b0, 3'd0);
`ifdef REG_BANK_BYPASS_EN
    qa1.push_back(16'h2222);
`else
    qa1.push_back(16'h1111);
`endif
    applyStimulus(1, 1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 1'b0, 3'd0);
    qa1.push_back(16'h2222);
    idle();
    checkOutput("written_after_addr5", {8'h00, written1}, 16'h0028);

    // Fill all entries, then dual-port reads including the same address on both.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 1'b1, 3'(i), 16'(16'h0100 + i), 1'b0, 3'd0, 1'b0, 3'd0);
    end
    applyStimulus(1, 1'b0, 3'd0, 16'h0, 1'b1, 3'd1, 1'b1, 3'd6);
    qa1.push_back(16'h0101);
    qb1.push_back(16'h0106);
    applyStimulus(1, 1'b0, 3'd0, 16'h0, 1'b1, 3'd1, 1'b1, 3'd1);
    qa1.push_back(16'h0101);
    qb1.push_back(16'h0101);
    applyStimulus(1, 1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 1'b1, 3'd7);
    qa1.push_back(16'h0103);
    qb1.push_back(16'h0107);
    idle();
    checkOutput("written_full", {8'h00, written1}, 16'h00FF);

    // Reset in the same cycle as a write discards the write and clears everything.
    applyStimulus(1, 1'b1, 3'd2, 16'hFFFF, 1'b0, 3'd0, 1'b0, 3'd0);
    rst = 1'b1;
    idle();
    checkOutput("midreset_rdata_a1", rdata_a1, 16'h0000);
    checkOutput("midreset_rdata_b1", rdata_b1, 16'h0000);
    checkOutput("midreset_written1", {8'h00, written1}, 16'h0000);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 1'b0, 3'd0, 16'h0, 1'b1, 3'(i), 1'b1, 3'(i));
      qa1.push_back(16'h0000);
      qb1.push_back(16'h0000);
    end
    idle();

    // Second instance: out-of-range addresses and the zero register.
    applyStimulus(2, 1'b1, 3'd7, 16'hAAAA, 1'b0, 3'd0, 1'b0, 3'd0);
    applyStimulus(2, 1'b0, 3'd0, 16'h0, 1'b1, 3'd7, 1'b0, 3'd0);
    qa2.push_back(16'h0000);
    idle();
    checkOutput("oob_written2", {10'h000, written2}, 16'h0000);
    applyStimulus(2, 1'b1, 3'd0, 16'h1234, 1'b0, 3'd0, 1'b0, 3'd0);
    applyStimulus(2, 1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 1'b1, 3'd0);
    qa2.push_back(16'h0000);
    qb2.push_back(16'h0000);
    idle();
    checkOutput("zeroreg_written2", {10'h000, written2}, 16'h0000);
    applyStimulus(2, 1'b1, 3'd5, 16'h5555, 1'b0, 3'd0, 1'b0, 3'd0);
    applyStimulus(2, 1'b1, 3'd6, 16'h7777, 1'b1, 3'd5, 1'b1, 3'd5);
    qa2.push_back(16'h5555);
    qb2.push_back(16'h5555);
    applyStimulus(2, 1'b0, 3'd0, 16'h0, 1'b1, 3'd6, 1'b1, 3'd4);
    qa2.push_back(16'h0000);
    qb2.push_back(16'h0000);
    idle();
    checkOutput("top_entry_written2", {10'h000, written2}, 16'h0020);
    applyStimulus(2, 1'b1, 3'd4, 16'h4444, 1'b1, 3'd4, 1'b1, 3'd0);
`ifdef REG_BANK_BYPASS_EN
    qa2.push_back(16'h4444);
`else
    qa2.push_back(16'h0000);
`endif
    qb2.push_back(16'h0000);
    applyStimulus(2, 1'b1, 3'd0, 16'h9999, 1'b1, 3'd0, 1'b1, 3'd4);
    qa2.push_back(16'h0000);
    qb2.push_back(16'h4444);
    idle();
    checkOutput("final_written2", {10'h000, written2}, 16'h0030);

    idle();
    checkOutput("drain_qa1", 16'(qa1.size()), 16'h0000);
    checkOutput("drain_qb1", 16'(qb1.size()), 16'h0000);
    checkOutput("drain_qa2", 16'(qa2.size()), 16'h0000);
    checkOutput("drain_qb2", 16'(qb2.size()), 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
